// File: rtl/sequencer_pkg.sv
// Shared constants, state encoding and control-word decode helpers for the instruction sequencer.
// The WAIT subop is only implemented in the sequencer when SEQ_WAIT_EN is defined.
package sequencer_pkg;

  localparam logic [4:0] CTRL_PREFIX = 5'b10111;

  localparam logic [1:0] SUB_HALT    = 2'b00;
  localparam logic [1:0] SUB_SETLOOP = 2'b01;
  localparam logic [1:0] SUB_LOOPJMP = 2'b10;
  localparam logic [1:0] SUB_WAIT    = 2'b11;

  // Opcode field bit positions
  localparam int CLASS_MSB = 15;
  localparam int CLASS_LSB = 11;
  localparam int SUBOP_MSB = 10;
  localparam int SUBOP_LSB = 9;
  localparam int WAIT_MSB  = 7;
  localparam int WAIT_LSB  = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    EXEC  = ST_EXEC,
    WAIT  = ST_WAIT
  } seq_state_t;

  function automatic logic is_ctrl(input logic [15:0] word);
    return word[CLASS_MSB:CLASS_LSB] == CTRL_PREFIX;
  endfunction

  function automatic logic [1:0] subop(input logic [15:0] word);
    return word[SUBOP_MSB:SUBOP_LSB];
  endfunction

  function automatic logic [7:0] wait_count(input logic [15:0] word);
    return word[WAIT_MSB:WAIT_LSB];
  endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: one synchronous write port and one registered read port.
module seq_prog_ram #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instruction_sequencer.sv
// Issues opcodes from a loadable program to the core array, consuming control words locally.
// Define SEQ_WAIT_EN to build the multi-cycle WAIT stall; otherwise WAIT is a one-slot no-op.
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           opcode,
  output logic                  execute
);

  seq_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [LOOP_WIDTH-1:0] loop_cnt_reg, loop_cnt_next;
  logic [15:0]           opcode_reg, opcode_next;
  logic [15:0]           ir;
  logic                  exec_core;
  logic                  run_end;
  logic                  advance;
  logic                  at_last;
`ifdef SEQ_WAIT_EN
  logic [7:0]            wait_cnt_reg, wait_cnt_next;
`endif

  seq_prog_ram #(
    .DEPTH      (PROG_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (16)
  ) u_ram (
    .clk   (clk),
    .we    (prog_we && (state_reg == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_reg == FETCH),
    .raddr (pc_reg),
    .rdata (ir)
  );

  assign at_last = &pc_reg;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    loop_cnt_next = loop_cnt_reg;
    opcode_next   = opcode_reg;
    exec_core     = 1'b0;
    run_end       = 1'b0;
    advance       = 1'b0;
`ifdef SEQ_WAIT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = EXEC;
      end
      EXEC: begin
        advance = 1'b1;
        if (!is_ctrl(ir)) begin
          exec_core   = 1'b1;
          opcode_next = ir;
        end else begin
          case (subop(ir))
            SUB_HALT: begin
              run_end = 1'b1;
              advance = 1'b0;
            end
            SUB_SETLOOP: begin
              loop_cnt_next = ir[LOOP_WIDTH-1:0];
            end
            SUB_LOOPJMP: begin
              // Taken jumps bypass the wrap check, so a loop may close from the last address.
              if (loop_cnt_reg != '0) begin
                loop_cnt_next = loop_cnt_reg - 1'b1;
                pc_next       = ir[ADDR_WIDTH-1:0];
                state_next    = FETCH;
                advance       = 1'b0;
              end
            end
            default: begin
`ifdef SEQ_WAIT_EN
              if (wait_count(ir) != 8'd0) begin
                wait_cnt_next = wait_count(ir);
                state_next    = WAIT;
                advance       = 1'b0;
              end
`endif
            end
          endcase
        end
        if (advance) begin
          if (at_last) begin
            run_end = 1'b1;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = FETCH;
          end
        end
        if (run_end) begin
          state_next = IDLE;
        end
      end
`ifdef SEQ_WAIT_EN
      WAIT: begin
        if (wait_cnt_reg == 8'd1) begin
          if (at_last) begin
            run_end    = 1'b1;
            state_next = IDLE;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = FETCH;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 8'd1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      loop_cnt_reg <= '0;
      opcode_reg   <= 16'h0000;
`ifdef SEQ_WAIT_EN
      wait_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      loop_cnt_reg <= loop_cnt_next;
      opcode_reg   <= opcode_next;
`ifdef SEQ_WAIT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  // Strobes are decoded from the registered EXEC state so an issue lands two cycles after start.
  assign execute = exec_core;
  assign done    = run_end;
  assign busy    = (state_reg != IDLE);
  assign opcode  = exec_core ? ir : opcode_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer; expectations follow SEQ_WAIT_EN if defined.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] opcode;
  logic        execute;

  int checks = 0;
  int failures = 0;
  int exec_cyc[$];
  logic [15:0] exec_op[$];

  instruction_sequencer #(
    .PROG_DEPTH (32),
    .ADDR_WIDTH (5),
    .LOOP_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .opcode    (opcode),
    .execute   (execute)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load(input logic [4:0] addr, input logic [15:0] data);
    prog_we = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  // Cycle 0 is the start cycle; records every execute pulse until done or budget expiry.
  task automatic run_prog(input int budget, input int poke_cyc, input logic poke_start,
                          input logic poke_we, input logic we_at_start, input logic [15:0] we_data,
                          output int n_exec, output int t_done);
    exec_cyc.delete();
    exec_op.delete();
    n_exec = 0;
    t_done = -1;
    start = 1'b1;
    prog_we = we_at_start;
    prog_addr = 5'd0;
    prog_data = we_data;
    tick();
    start = 1'b0;
    prog_we = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (execute) begin
        exec_cyc.push_back(c);
        exec_op.push_back(opcode);
        n_exec++;
      end
      if (done) begin
        t_done = c;
        break;
      end
      start = (c == poke_cyc) && poke_start;
      prog_we = (c == poke_cyc) && poke_we;
      tick();
    end
    start = 1'b0;
    prog_we = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    int td;
    int bad;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_execute", 32'(execute), 32'd0);
    chk("reset_opcode", 32'(opcode), 32'h0000);

    // Test 1: single issue then HALT, cycle-exact
    load(5'd0, 16'h1234);
    load(5'd1, 16'hB800);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_execute", 32'(execute), 32'd0);
    tick();
    chk("t1_c2_execute", 32'(execute), 32'd1);
    chk("t1_c2_opcode", 32'(opcode), 32'h1234);
    tick();
    chk("t1_c3_execute", 32'(execute), 32'd0);
    chk("t1_c3_opcode_hold", 32'(opcode), 32'h1234);
    chk("t1_c3_done", 32'(done), 32'd0);
    tick();
    chk("t1_c4_done", 32'(done), 32'd1);
    chk("t1_c4_busy", 32'(busy), 32'd1);
    chk("t1_c4_execute", 32'(execute), 32'd0);
    tick();
    chk("t1_c5_busy", 32'(busy), 32'd0);
    chk("t1_c5_done", 32'(done), 32'd0);

    // Test 2: SETLOOP 3 runs the body four times
    load(5'd0, 16'hBA03);
    load(5'd1, 16'h00AA);
    load(5'd2, 16'hBC01);
    load(5'd3, 16'hB800);
    run_prog(200, -1, 1'b0, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t2_exec_count", 32'(n), 32'd4);
    bad = 0;
    foreach (exec_op[i]) if (exec_op[i] !== 16'h00AA) bad++;
    chk("t2_bad_opcodes", 32'(bad), 32'd0);
    if (n == 4) begin
      chk("t2_first_exec_cyc", 32'(exec_cyc[0]), 32'd4);
      chk("t2_last_exec_cyc", 32'(exec_cyc[3]), 32'd16);
    end
    chk("t2_done_cyc", 32'(td), 32'd20);
    chk("t2_opcode_hold", 32'(opcode), 32'h00AA);

    // Test 3: WAIT 5 between two core words
    load(5'd0, 16'h1111);
    load(5'd1, 16'hBE05);
    load(5'd2, 16'h2222);
    load(5'd3, 16'hB800);
    run_prog(200, -1, 1'b0, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t3_exec_count", 32'(n), 32'd2);
    if (n == 2) begin
      chk("t3_op0", 32'(exec_op[0]), 32'h1111);
      chk("t3_op1", 32'(exec_op[1]), 32'h2222);
`ifdef SEQ_WAIT_EN
      chk("t3_issue_gap", 32'(exec_cyc[1] - exec_cyc[0]), 32'd9);
`else
      chk("t3_issue_gap", 32'(exec_cyc[1] - exec_cyc[0]), 32'd4);
`endif
    end
`ifdef SEQ_WAIT_EN
    chk("t3_done_cyc", 32'(td), 32'd13);
`else
    chk("t3_done_cyc", 32'(td), 32'd8);
`endif

    // Test 3b: WAIT 0 is a plain no-op slot
    load(5'd1, 16'hBE00);
    run_prog(200, -1, 1'b0, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t3b_exec_count", 32'(n), 32'd2);
    if (n == 2) chk("t3b_issue_gap", 32'(exec_cyc[1] - exec_cyc[0]), 32'd4);

    // Test 4: 32 core words, implicit HALT at wrap, mid-run start ignored
    for (int i = 0; i < 32; i++) load(5'(i), 16'h0100 + 16'(i));
    run_prog(300, 10, 1'b1, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t4_exec_count", 32'(n), 32'd32);
    bad = 0;
    foreach (exec_op[i]) if (exec_op[i] !== (16'h0100 + 16'(i))) bad++;
    chk("t4_bad_opcodes", 32'(bad), 32'd0);
    if (n == 32) chk("t4_last_exec_cyc", 32'(exec_cyc[31]), 32'd64);
    chk("t4_done_cyc", 32'(td), 32'd64);
    chk("t4_busy_after", 32'(busy), 32'd0);

    // Test 5: prog_we while busy is dropped
    load(5'd0, 16'h4321);
    load(5'd1, 16'hB800);
    run_prog(100, 2, 1'b0, 1'b1, 1'b0, 16'h5555, n, td);
    chk("t5_run1_count", 32'(n), 32'd1);
    run_prog(100, -1, 1'b0, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t5_run2_count", 32'(n), 32'd1);
    if (n == 1) chk("t5_run2_op", 32'(exec_op[0]), 32'h4321);

    // Test 5b: write and start in the same idle cycle fetches the new word
    run_prog(100, -1, 1'b0, 1'b0, 1'b1, 16'h7777, n, td);
    chk("t5b_count", 32'(n), 32'd1);
    if (n == 1) chk("t5b_op", 32'(exec_op[0]), 32'h7777);

    // Test 6: reset on the execute cycle
    load(5'd0, 16'h0ABC);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_pre_execute", 32'(execute), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_execute", 32'(execute), 32'd0);
    chk("t6_rst_opcode", 32'(opcode), 32'h0000);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (execute !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || opcode !== 16'h0000) bad++;
    end
    chk("t6_quiet_cycles", 32'(bad), 32'd0);
    run_prog(100, -1, 1'b0, 1'b0, 1'b0, 16'h0000, n, td);
    chk("t6_rerun_count", 32'(n), 32'd1);
    if (n == 1) begin
      chk("t6_rerun_op", 32'(exec_op[0]), 32'h0ABC);
      chk("t6_rerun_cyc", 32'(exec_cyc[0]), 32'd2);
    end
    chk("t6_rerun_done", 32'(td), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Upstream stage of the GPU core array: holds a small loadable program and issues one 16-bit opcode per issue slot, with a single-cycle execute strobe.
- Sequencer-local control words (HALT, SETLOOP, LOOPJMP, WAIT) are consumed internally and never reach the cores.
- A run is started once per work item (e.g. per pixel) by the frame/timing logic; done reports completion.

Parameters:
- PROG_DEPTH, 32, number of 16-bit program words (power of two).
- ADDR_WIDTH, 5, program counter / program address width; must equal log2(PROG_DEPTH).
- LOOP_WIDTH, 8, width of the loop counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- prog_we  input  1  program write enable
- prog_addr  input  ADDR_WIDTH  program write address
- prog_data  input  16  program write data
- start  input  1  begin execution at address 0
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run ends
- opcode  output  16  opcode to core array; held stable between issues
- execute  output  1  one-cycle strobe qualifying opcode

Behaviour:
- Single clock domain; one clock and a synchronous, active-high reset, as fixed above.
- Reset values:
  - busy=0, done=0, execute=0, opcode=16'h0000.
  - pc=0, loop counter=0, state=IDLE.
  - Program RAM contents are not reset.
- Control-word class: ir[15:11]==5'b10111. Subop ir[10:9]:
  - 00 HALT.
  - 01 SETLOOP: counter <= ir[LOOP_WIDTH-1:0].
  - 10 LOOPJMP: target ir[ADDR_WIDTH-1:0].
  - 11 WAIT: n = ir[7:0] idle cycles.
- All other words are core instructions and are forwarded.
- States: IDLE, FETCH, EXEC, WAIT.
  - IDLE: start=1 -> pc<=0, busy<=1, go to FETCH. prog_we writes only in IDLE.
  - FETCH: synchronous RAM read of mem[pc] into ir; go to EXEC.
  - EXEC, core instruction: opcode<=ir, execute<=1 for exactly this cycle.
  - EXEC, SETLOOP: load counter.
  - EXEC, LOOPJMP: if counter!=0, counter<=counter-1 and pc<=target; else fall through, counter stays 0.
  - EXEC, WAIT: load wait counter with n, go to WAIT. If n=0, behave as a no-op.
  - EXEC, HALT: busy<=0, done<=1 (one cycle), go to IDLE.
  - EXEC, otherwise: pc<=pc+1, go to FETCH.
  - WAIT: decrement each cycle. At 1, pc<=pc+1 and go to FETCH. Total stall is n cycles.
- Throughput: one issue per 2 cycles. First execute appears 2 cycles after the start cycle (start at T -> execute at T+2).
- Loop semantics: SETLOOP k followed by a body ending in LOOPJMP runs the body k+1 times.
- Boundary conditions:
  - pc wrap: EXEC at address PROG_DEPTH-1 that would advance to pc+1 ends the run as an implicit HALT (done pulse, IDLE). A LOOPJMP taken from the last address still jumps.
  - start while busy: ignored.
  - prog_we while busy: write dropped.
  - prog_we and start in the same IDLE cycle: the write completes; the run starts and fetches post-write contents (fetch occurs the next cycle).
  - reset mid-run: immediate return to reset values; any in-flight execute is suppressed the following cycle.
  - opcode: holds its last issued value when execute=0. Control words never modify opcode.

Optional Feature:
- Macro: SEQ_WAIT_EN.
- Defined: WAIT subop implemented as above.
- Undefined: WAIT is a 1-issue-slot no-op (pc<=pc+1, no stall); no wait counter is synthesised.

Decomposition:
- Package sequencer_pkg:
  - CTRL_PREFIX=5'b10111.
  - Subop constants SUB_HALT, SUB_SETLOOP, SUB_LOOPJMP, SUB_WAIT.
  - State enum seq_state_t {IDLE, FETCH, EXEC, WAIT}.
  - Opcode field bit positions.
- Sub-module seq_prog_ram:
  - PROG_DEPTH x 16, one synchronous write port, one synchronous read port.
  - Read data registered one cycle.

Test Plan:
1. Load mem[0]=16'h1234, mem[1]=16'hB800 (HALT); pulse start at T.
   - Required: execute=1 with opcode=16'h1234 at T+2 only.
   - Required: done=1 at T+4; busy high T+1..T+4, low at T+5.
2. Loop: mem[0]=SETLOOP 3 (16'hBA03), mem[1]=16'h00AA, mem[2]=LOOPJMP 1 (16'hBC01), mem[3]=HALT.
   - Required: exactly 4 execute pulses, all with opcode=16'h00AA, then done.
3. WAIT 5 (16'hBE05) between two core words.
   - With SEQ_WAIT_EN: issue gap is 2+5+2 cycles.
   - Without SEQ_WAIT_EN: gap is 4 cycles.
4. Program of 32 core words, no HALT.
   - Required: 32 execute pulses, then implicit done.
   - Required: start pulsed mid-run has no effect.
5. prog_we to addr 0 while busy.
   - Required: the write is dropped, so the next run issues the old word.
6. Assert reset at the cycle execute would rise.
   - Required: execute=0 on all following cycles, opcode=0, busy=0, done=0.
   - Required: a fresh start re-runs from address 0.
